// File: rtl/chunk_row_iter_pkg.sv
// Shared types for the chunk row iterator: FSM state, per-dimension row flags and default sizing.
package ChunkRowPkg;

    localparam int DEF_DIM   = 3;
    localparam int DEF_GBW   = 16;
    localparam int DEF_VSIZE = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } iter_state_t;

    typedef struct packed {
        logic valid;
        logic at_last;
    } dim_rec_t;

endpackage

// File: rtl/chunk_row_iter_clamp.sv
// One dimension's counter+offset resolved against its bound (clamp or modular wrap).
// Purely combinational; no latency, no backpressure.
module chunk_row_clamp
    import ChunkRowPkg::*;
#(
    parameter int GBW = DEF_GBW
) (
    input  logic [GBW-1:0] cnt,
    input  logic [GBW-1:0] ofs,
    input  logic [GBW-1:0] bound,
    input  logic [GBW-1:0] bound_next,
    input  logic [GBW-1:0] last,
    input  logic           wrapmode,
    output logic [GBW-1:0] clamp,
    output dim_rec_t       rec
);

    logic [GBW-1:0] u;

    assign u = cnt + ofs;

    always_comb begin
        clamp       = u;
        rec.valid   = 1'b1;
        rec.at_last = (cnt == last);
        if (u[GBW-1]) begin
            if (wrapmode) begin
                clamp = u + bound;
            end else begin
                clamp     = '0;
                rec.valid = 1'b0;
            end
        end else if ($signed(u) >= $signed(bound)) begin
            // Out-of-range rows clamp to the start of the last inner slice.
            if (wrapmode) begin
                clamp = u - bound;
            end else begin
                clamp     = bound - bound_next;
                rec.valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/chunk_row_iter.sv
// Walks the rows of a chunk descriptor, one registered row per cycle; row 0 the cycle after mofs_ack, held until row_ack.
// Optional CHUNK_ROW_ITER_SKIP_INVALID_EN drops out-of-bounds rows (except the final one) at one per cycle.
module chunk_row_iter
    import ChunkRowPkg::*;
#(
    parameter  int DIM   = DEF_DIM,
    parameter  int GBW   = DEF_GBW,
    parameter  int VSIZE = DEF_VSIZE,
    localparam int V_BW  = $clog2(VSIZE)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     mofs_rdy,
    output logic                     mofs_ack,
    input  logic [DIM-1:0][GBW-1:0]  i_mofs,
    input  logic [DIM-1:0][V_BW-1:0] i_mpad,
    input  logic [DIM-1:0][GBW-1:0]  i_mbound,
    input  logic [DIM-1:0][GBW-1:0]  i_mlast,
    input  logic [GBW-1:0]           i_maddr,
    input  logic                     i_wrap,
    input  logic [DIM-2:0]           i_wrapmode,
    output logic                     row_rdy,
    input  logic                     row_ack,
    output logic [GBW-1:0]           o_row_linear,
    output logic                     o_row_islast,
    output logic [V_BW-1:0]          o_row_pad,
    output logic                     o_row_valid
);

`ifdef CHUNK_ROW_ITER_SKIP_INVALID_EN
    localparam bit SKIP_INVALID = 1'b1;
`else
    localparam bit SKIP_INVALID = 1'b0;
`endif

    iter_state_t state;

    logic [DIM-2:0][GBW-1:0]  ofs_q, last_q, cur;
    logic [DIM-1:0][GBW-1:0]  bound_q;
    logic [DIM-1:0][V_BW-1:0] pad_q;
    logic [GBW-1:0]           base_q;
    logic                     wrap_q;
    logic [DIM-2:0]           wmode_q;

    logic [DIM-2:0][GBW-1:0]  src_ofs, src_last, cand, clamp;
    logic [DIM-1:0][GBW-1:0]  src_bound;
    logic [DIM-1:0][V_BW-1:0] src_pad;
    logic [GBW-1:0]           src_base, cand_lin;
    logic                     src_wrap, cand_valid, cand_last;
    logic [DIM-2:0]           src_wmode;
    logic [V_BW-1:0]          cand_pad;
    dim_rec_t [DIM-2:0]       rec;

    logic accept, finish, run_step, load, skip;
    logic unused_ok;

    assign unused_ok = ^{i_mofs[DIM-1], i_mlast[DIM-1]};

    // On the accept edge row 0 is built straight from the descriptor inputs.
    assign accept    = (state == IDLE) && mofs_ack;
    assign src_ofs   = accept ? i_mofs[DIM-2:0]  : ofs_q;
    assign src_last  = accept ? i_mlast[DIM-2:0] : last_q;
    assign src_bound = accept ? i_mbound         : bound_q;
    assign src_pad   = accept ? i_mpad           : pad_q;
    assign src_base  = accept ? i_maddr          : base_q;
    assign src_wrap  = accept ? i_wrap           : wrap_q;
    assign src_wmode = accept ? i_wrapmode       : wmode_q;

    always_comb begin
        logic carry;
        carry = 1'b1;
        cand  = cur;
        for (int i = DIM - 2; i >= 0; i--) begin
            if (carry) begin
                if (cur[i] == last_q[i]) begin
                    cand[i] = '0;
                end else begin
                    cand[i] = cur[i] + bound_q[i+1];
                    carry   = 1'b0;
                end
            end
        end
        if (accept) begin
            cand = '0;
        end
    end

    for (genvar g = 0; g < DIM - 1; g++) begin : g_dim
        chunk_row_clamp #(.GBW(GBW)) u_clamp (
            .cnt        (cand[g]),
            .ofs        (src_ofs[g]),
            .bound      (src_bound[g]),
            .bound_next (src_bound[g+1]),
            .last       (src_last[g]),
            .wrapmode   (src_wmode[g]),
            .clamp      (clamp[g]),
            .rec        (rec[g])
        );
    end

    // Pad comes from the outermost dim whose whole inner suffix sits at its last value.
    always_comb begin
        logic all_valid;
        all_valid = 1'b1;
        cand_last = 1'b1;
        cand_lin  = src_base;
        cand_pad  = src_pad[DIM-1];
        for (int i = DIM - 2; i >= 0; i--) begin
            cand_lin  = cand_lin + clamp[i];
            all_valid = all_valid & rec[i].valid;
            cand_last = cand_last & rec[i].at_last;
            if (cand_last) begin
                cand_pad = src_pad[i];
            end
        end
        cand_valid = src_wrap | all_valid;
    end

    assign skip     = SKIP_INVALID && !cand_valid && !cand_last;
    assign finish   = (state == RUN) && row_rdy && row_ack && o_row_islast;
    assign run_step = (state == RUN) && (!row_rdy || row_ack) && !(row_rdy && o_row_islast);
    assign load     = accept || run_step;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            mofs_ack     <= 1'b0;
            row_rdy      <= 1'b0;
            o_row_linear <= '0;
            o_row_islast <= 1'b0;
            o_row_pad    <= '0;
            o_row_valid  <= 1'b0;
            cur          <= '0;
            ofs_q        <= '0;
            last_q       <= '0;
            bound_q      <= '0;
            pad_q        <= '0;
            base_q       <= '0;
            wrap_q       <= 1'b0;
            wmode_q      <= '0;
        end else begin
            if (state == IDLE) begin
                if (mofs_ack) begin
                    mofs_ack <= 1'b0;
                    state    <= RUN;
                    ofs_q    <= i_mofs[DIM-2:0];
                    last_q   <= i_mlast[DIM-2:0];
                    bound_q  <= i_mbound;
                    pad_q    <= i_mpad;
                    base_q   <= i_maddr;
                    wrap_q   <= i_wrap;
                    wmode_q  <= i_wrapmode;
                end else begin
                    mofs_ack <= mofs_rdy;
                end
            end else if (finish) begin
                state   <= IDLE;
                row_rdy <= 1'b0;
            end
            if (load) begin
                cur     <= cand;
                row_rdy <= !skip;
                if (!skip) begin
                    o_row_linear <= cand_lin;
                    o_row_islast <= cand_last;
                    o_row_pad    <= cand_pad;
                    o_row_valid  <= cand_valid;
                end
            end
        end
    end

endmodule

// File: tb/tb_chunk_row_iter.sv
// Bench for chunk_row_iter: directed chunk cases, backpressure/reset, then random descriptors against a nested-loop model.
module tb_chunk_row_iter;

    localparam int DIM   = 3;
    localparam int GBW   = 16;
    localparam int VSIZE = 16;
    localparam int V_BW  = 4;

    logic                     i_clk = 1'b0;
    logic                     i_rst;
    logic                     mofs_rdy, mofs_ack;
    logic [DIM-1:0][GBW-1:0]  i_mofs, i_mbound, i_mlast;
    logic [DIM-1:0][V_BW-1:0] i_mpad;
    logic [GBW-1:0]           i_maddr;
    logic                     i_wrap;
    logic [DIM-2:0]           i_wrapmode;
    logic                     row_rdy, row_ack;
    logic [GBW-1:0]           o_row_linear;
    logic                     o_row_islast, o_row_valid;
    logic [V_BW-1:0]          o_row_pad;

    always #5 i_clk = ~i_clk;

    chunk_row_iter #(.DIM(DIM), .GBW(GBW), .VSIZE(VSIZE)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .mofs_rdy     (mofs_rdy),
        .mofs_ack     (mofs_ack),
        .i_mofs       (i_mofs),
        .i_mpad       (i_mpad),
        .i_mbound     (i_mbound),
        .i_mlast      (i_mlast),
        .i_maddr      (i_maddr),
        .i_wrap       (i_wrap),
        .i_wrapmode   (i_wrapmode),
        .row_rdy      (row_rdy),
        .row_ack      (row_ack),
        .o_row_linear (o_row_linear),
        .o_row_islast (o_row_islast),
        .o_row_pad    (o_row_pad),
        .o_row_valid  (o_row_valid)
    );

`ifdef CHUNK_ROW_ITER_SKIP_INVALID_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int d_ofs0, d_ofs1, d_b0, d_b1, d_b2, d_l0, d_l1, d_base;
    int d_pad[3];
    bit d_wrap;
    bit [1:0] d_wm;

    int e_lin[$], e_val[$], e_last[$], e_pad[$], e_idx[$];
    int o_lin[$], o_val[$];
    int lit_l[4], lit_v[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int resolve(input int c, input int ofs, input int b, input int bn,
                                   input bit wm, output bit v);
        int u;
        u = c + ofs;
        v = 1'b1;
        if (u < 0) begin
            if (wm) return u + b;
            v = 1'b0;
            return 0;
        end
        if (u >= b) begin
            if (wm) return u - b;
            v = 1'b0;
            return b - bn;
        end
        return u;
    endfunction

    task automatic build_model();
        int idx;
        idx = 0;
        e_lin.delete(); e_val.delete(); e_last.delete(); e_pad.delete(); e_idx.delete();
        for (int c0 = 0; c0 <= d_l0; c0 += d_b1) begin
            for (int c1 = 0; c1 <= d_l1; c1 += d_b2) begin
                bit v0, v1, last;
                int lin, pad, val;
                lin  = (d_base + resolve(c0, d_ofs0, d_b0, d_b1, d_wm[0], v0)
                               + resolve(c1, d_ofs1, d_b1, d_b2, d_wm[1], v1)) & 'hFFFF;
                last = (c0 == d_l0) && (c1 == d_l1);
                pad  = last ? d_pad[0] : (c1 == d_l1) ? d_pad[1] : d_pad[2];
                val  = int'(d_wrap | (v0 & v1));
                if (val != 0 || last || !SKIP) begin
                    e_lin.push_back(lin); e_val.push_back(val); e_last.push_back(int'(last));
                    e_pad.push_back(pad); e_idx.push_back(idx);
                end
                idx++;
            end
        end
    endtask

    task automatic set_base();
        d_b0 = 16; d_b1 = 8; d_b2 = 1; d_l0 = 8; d_l1 = 1; d_base = 100;
        d_pad[0] = 1; d_pad[1] = 2; d_pad[2] = 3;
        d_ofs0 = 0; d_ofs1 = 0; d_wrap = 1'b0; d_wm = 2'b00;
    endtask

    task automatic scramble();
        i_mofs = {3{16'($urandom)}}; i_mbound = {3{16'($urandom)}}; i_mlast = {3{16'($urandom)}};
        i_mpad = 12'($urandom); i_maddr = 16'($urandom); i_wrap = 1'($urandom); i_wrapmode = 2'($urandom);
    endtask

    // Handshake a descriptor; leaves the bench at the negedge after acceptance.
    task automatic start_desc();
        i_mofs[0] = 16'(d_ofs0); i_mofs[1] = 16'(d_ofs1); i_mofs[2] = 16'($urandom);
        i_mbound[0] = 16'(d_b0); i_mbound[1] = 16'(d_b1); i_mbound[2] = 16'(d_b2);
        i_mlast[0] = 16'(d_l0); i_mlast[1] = 16'(d_l1); i_mlast[2] = 16'($urandom);
        for (int k = 0; k < 3; k++) i_mpad[k] = 4'(d_pad[k]);
        i_maddr = 16'(d_base); i_wrap = d_wrap; i_wrapmode = d_wm;
        mofs_rdy = 1'b1;
        @(negedge i_clk);
        check("ack_lat", mofs_ack, 1);
        mofs_rdy = 1'b0;
        @(negedge i_clk);
        check("ack_pulse", mofs_ack, 0);
        scramble();
    endtask

    task automatic drain(input int ack_pct);
        int k, idle;
        k = 0; idle = 0;
        o_lin.delete(); o_val.delete();
        if (e_idx[0] == 0) check("row0_lat", row_rdy, 1);
        while (k < e_lin.size()) begin
            if (row_rdy) begin
                check("row_lin", o_row_linear, e_lin[k]);
                check("row_valid", o_row_valid, e_val[k]);
                check("row_islast", o_row_islast, e_last[k]);
                check("row_pad", o_row_pad, e_pad[k]);
                if ($urandom_range(0, 99) < ack_pct) begin
                    row_ack = 1'b1;
                    o_lin.push_back(int'(o_row_linear));
                    o_val.push_back(int'(o_row_valid));
                    k++;
                    idle = 0;
                end
            end
            idle++;
            if (idle > 40) begin
                check("row_timeout", idle, 0);
                break;
            end
            @(negedge i_clk);
            row_ack = 1'b0;
        end
        check("done_rdy", row_rdy, 0);
        check("done_ack", mofs_ack, 0);
    endtask

    task automatic check_list(input string tag, input int n);
        check({tag, "_n"}, o_lin.size(), n);
        for (int i = 0; i < n && i < o_lin.size(); i++) begin
            check({tag, "_lin"}, o_lin[i], lit_l[i]);
            check({tag, "_val"}, o_val[i], lit_v[i]);
        end
    endtask

    initial begin
        i_rst = 1'b1; mofs_rdy = 1'b0; row_ack = 1'b0;
        scramble();
        repeat (3) @(negedge i_clk);
        check("rst_rdy", row_rdy, 0);
        check("rst_ack", mofs_ack, 0);
        check("rst_lin", o_row_linear, 0);
        check("rst_last", o_row_islast, 0);
        check("rst_valid", o_row_valid, 0);
        check("rst_pad", o_row_pad, 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        set_base(); build_model(); start_desc(); drain(100);
        lit_l = '{100, 101, 108, 109}; lit_v = '{1, 1, 1, 1};
        check_list("c_ofs0", 4);

        set_base(); d_ofs0 = -8; build_model(); start_desc(); drain(70);
`ifdef CHUNK_ROW_ITER_SKIP_INVALID_EN
        lit_l = '{100, 101, 0, 0}; lit_v = '{1, 1, 0, 0};
        check_list("c_neg", 2);
`else
        lit_l = '{100, 101, 100, 101}; lit_v = '{0, 0, 1, 1};
        check_list("c_neg", 4);
`endif

        d_wrap = 1'b1; build_model(); start_desc(); drain(100);
        lit_l = '{100, 101, 100, 101}; lit_v = '{1, 1, 1, 1};
        check_list("c_neg_wrap", 4);

        set_base(); d_ofs0 = -8; d_wm = 2'b01; build_model(); start_desc(); drain(60);
        lit_l = '{108, 109, 100, 101}; lit_v = '{1, 1, 1, 1};
        check_list("c_wrapmode", 4);

        set_base(); d_ofs0 = 8; build_model(); start_desc(); drain(100);
`ifdef CHUNK_ROW_ITER_SKIP_INVALID_EN
        lit_l = '{108, 109, 109, 0}; lit_v = '{1, 1, 0, 0};
        check_list("c_pos", 3);
`else
        lit_l = '{108, 109, 108, 109}; lit_v = '{1, 1, 0, 0};
        check_list("c_pos", 4);
`endif

        set_base(); d_l0 = 0; d_l1 = 0; build_model(); start_desc(); drain(100);
        lit_l = '{100, 0, 0, 0}; lit_v = '{1, 0, 0, 0};
        check_list("c_single", 1);

        // Backpressure hold on row 1, then reset while row 2 is presented.
        set_base(); start_desc();
        check("bp_row0", o_row_linear, 100);
        row_ack = 1'b1;
        @(negedge i_clk);
        row_ack = 1'b0;
        check("bp_row1", o_row_linear, 101);
        repeat (3) begin
            @(negedge i_clk);
            check("hold_lin", o_row_linear, 101);
            check("hold_rdy", row_rdy, 1);
            check("hold_last", o_row_islast, 0);
        end
        row_ack = 1'b1;
        @(negedge i_clk);
        row_ack = 1'b0;
        check("bp_row2", o_row_linear, 108);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("midrst_rdy", row_rdy, 0);
        check("midrst_ack", mofs_ack, 0);
        check("midrst_lin", o_row_linear, 0);
        repeat (3) begin
            @(negedge i_clk);
            check("post_rst_rdy", row_rdy, 0);
        end

        repeat (40) begin
            d_b2 = $urandom_range(1, 4);
            d_b1 = $urandom_range(1, 12);
            d_b0 = $urandom_range(1, 40);
            d_l0 = d_b1 * $urandom_range(0, 3);
            d_l1 = d_b2 * $urandom_range(0, 3);
            d_ofs0 = int'($urandom_range(0, 60)) - 30;
            d_ofs1 = int'($urandom_range(0, 30)) - 15;
            for (int k = 0; k < 3; k++) d_pad[k] = $urandom_range(0, 15);
            d_base = $urandom_range(0, 65535);
            d_wrap = ($urandom_range(0, 7) == 0);
            d_wm   = 2'($urandom_range(0, 3));
            build_model();
            start_desc();
            drain($urandom_range(30, 100));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
